// File: rtl/cmul_mult_sequencer_pkg.sv
// Shared types and constants for the complex-multiply sequencer around a serial 8x9 multiplier.
// Includes product-order operand selectors so the FSM and any checker agree on the k order.
package cmul_mult_sequencer_pkg;

  localparam int unsigned XW = 8;
  localparam int unsigned WW = 9;
  localparam int unsigned PW = XW + WW;

  localparam int unsigned TIMEOUT_DEF   = 64;
  localparam int unsigned FLUSH_CYC_DEF = 20;

  localparam logic [1:0] K_RR = 2'd0;
  localparam logic [1:0] K_II = 2'd1;
  localparam logic [1:0] K_RI = 2'd2;
  localparam logic [1:0] K_IR = 2'd3;

  typedef enum logic [2:0] {
    StFlush,
    StIdle,
    StIssue,
    StWait,
    StCombine,
    StOut
  } state_e;

  function automatic logic signed [XW-1:0] sel_a(input logic [1:0] k,
                                                 input logic signed [XW-1:0] re,
                                                 input logic signed [XW-1:0] im);
    case (k)
      K_RR:    return re;
      K_II:    return im;
      K_RI:    return re;
      default: return im;
    endcase
  endfunction

  function automatic logic signed [WW-1:0] sel_b(input logic [1:0] k,
                                                 input logic signed [WW-1:0] re,
                                                 input logic signed [WW-1:0] im);
    case (k)
      K_RR:    return re;
      K_II:    return im;
      K_RI:    return im;
      default: return re;
    endcase
  endfunction

  function automatic logic signed [PW:0] sext_p(input logic signed [PW-1:0] p);
    return {p[PW-1], p};
  endfunction

endpackage

// File: rtl/cmul_mult_sequencer_if.sv
// Operand, result and multiplier-side signals of the complex-multiply sequencer.
// master is the sequencer's view; slave is the environment (source, sink and multiplier).
interface cmul_mult_sequencer_if;
  import cmul_mult_sequencer_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [XW-1:0] x_re;
  logic signed [XW-1:0] x_im;
  logic signed [WW-1:0] w_re;
  logic signed [WW-1:0] w_im;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [PW:0]   out_re;
  logic signed [PW:0]   out_im;

  logic                 mul_start;
  logic signed [XW-1:0] mul_a;
  logic signed [WW-1:0] mul_b;
  logic                 mul_valid;
  logic signed [PW-1:0] mul_p;

  logic                 err;

  modport master (
    input  in_valid, x_re, x_im, w_re, w_im, out_ready, mul_valid, mul_p,
    output in_ready, out_valid, out_re, out_im, mul_start, mul_a, mul_b, err
  );

  modport slave (
    output in_valid, x_re, x_im, w_re, w_im, out_ready, mul_valid, mul_p,
    input  in_ready, out_valid, out_re, out_im, mul_start, mul_a, mul_b, err
  );

endinterface

// File: rtl/cmul_mult_sequencer.sv
// Drives a shared serial multiplier through four real products and combines them into one
// complex result; a watchdog aborts to FLUSH if the multiplier stops answering.
module cmul_mult_sequencer
  import cmul_mult_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned FLUSH_CYC = FLUSH_CYC_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  cmul_mult_sequencer_if.master bus
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned FlW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  state_e                        r_state_q, r_state_d;
  logic [FlW-1:0]                r_flush_q, r_flush_d;
  logic [WdW-1:0]                r_wd_q, r_wd_d;
  logic [1:0]                    r_k_q, r_k_d;
  logic signed [XW-1:0]          r_x_re_q, r_x_re_d, r_x_im_q, r_x_im_d;
  logic signed [WW-1:0]          r_w_re_q, r_w_re_d, r_w_im_q, r_w_im_d;
  logic signed [XW-1:0]          r_mul_a_q, r_mul_a_d;
  logic signed [WW-1:0]          r_mul_b_q, r_mul_b_d;
  logic [3:0][PW-1:0]            r_p_q, r_p_d;
  logic signed [PW:0]            r_out_re_q, r_out_re_d, r_out_im_q, r_out_im_d;
  logic                          r_out_valid_q, r_out_valid_d;
  logic                          r_err_q, r_err_d;
  logic [1:0]                    w_k_next;

  assign w_k_next = r_k_q + 2'd1;

  always_comb begin
    r_state_d     = r_state_q;
    r_flush_d     = r_flush_q;
    r_wd_d        = r_wd_q;
    r_k_d         = r_k_q;
    r_x_re_d      = r_x_re_q;
    r_x_im_d      = r_x_im_q;
    r_w_re_d      = r_w_re_q;
    r_w_im_d      = r_w_im_q;
    r_mul_a_d     = r_mul_a_q;
    r_mul_b_d     = r_mul_b_q;
    r_p_d         = r_p_q;
    r_out_re_d    = r_out_re_q;
    r_out_im_d    = r_out_im_q;
    r_out_valid_d = r_out_valid_q;
    r_err_d       = r_err_q;

    unique case (r_state_q)
      StFlush: begin
        if (r_flush_q == FlW'(FLUSH_CYC - 1)) begin
          r_flush_d = '0;
          r_state_d = StIdle;
        end else begin
          r_flush_d = r_flush_q + 1'b1;
        end
      end
      StIdle: begin
        if (bus.in_valid) begin
          r_x_re_d  = bus.x_re;
          r_x_im_d  = bus.x_im;
          r_w_re_d  = bus.w_re;
          r_w_im_d  = bus.w_im;
          r_k_d     = K_RR;
          // Operands are loaded on entry so they are already valid in the start cycle.
          r_mul_a_d = sel_a(K_RR, bus.x_re, bus.x_im);
          r_mul_b_d = sel_b(K_RR, bus.w_re, bus.w_im);
          r_state_d = StIssue;
        end
      end
      StIssue: begin
        r_wd_d    = '0;
        r_state_d = StWait;
      end
      StWait: begin
        if (bus.mul_valid) begin
          r_p_d[r_k_q] = bus.mul_p;
          if (r_k_q == K_IR) begin
            r_state_d = StCombine;
          end else begin
            r_k_d     = w_k_next;
            r_mul_a_d = sel_a(w_k_next, r_x_re_q, r_x_im_q);
            r_mul_b_d = sel_b(w_k_next, r_w_re_q, r_w_im_q);
            r_state_d = StIssue;
          end
        end else if (r_wd_q == WdW'(TIMEOUT - 1)) begin
          r_err_d   = 1'b1;
          r_flush_d = '0;
          r_state_d = StFlush;
        end else begin
          r_wd_d = r_wd_q + 1'b1;
        end
      end
      StCombine: begin
        // 17-bit products sign-extended to 18 bits cannot overflow in one add/sub.
        r_out_re_d    = sext_p(r_p_q[K_RR]) - sext_p(r_p_q[K_II]);
        r_out_im_d    = sext_p(r_p_q[K_RI]) + sext_p(r_p_q[K_IR]);
        r_out_valid_d = 1'b1;
        r_state_d     = StOut;
      end
      StOut: begin
        if (bus.out_ready) begin
          r_out_valid_d = 1'b0;
          r_state_d     = StIdle;
        end
      end
      default: begin
        r_flush_d = '0;
        r_state_d = StFlush;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q     <= StFlush;
      r_flush_q     <= '0;
      r_wd_q        <= '0;
      r_k_q         <= K_RR;
      r_x_re_q      <= '0;
      r_x_im_q      <= '0;
      r_w_re_q      <= '0;
      r_w_im_q      <= '0;
      r_mul_a_q     <= '0;
      r_mul_b_q     <= '0;
      r_p_q         <= '0;
      r_out_re_q    <= '0;
      r_out_im_q    <= '0;
      r_out_valid_q <= 1'b0;
      r_err_q       <= 1'b0;
    end else begin
      r_state_q     <= r_state_d;
      r_flush_q     <= r_flush_d;
      r_wd_q        <= r_wd_d;
      r_k_q         <= r_k_d;
      r_x_re_q      <= r_x_re_d;
      r_x_im_q      <= r_x_im_d;
      r_w_re_q      <= r_w_re_d;
      r_w_im_q      <= r_w_im_d;
      r_mul_a_q     <= r_mul_a_d;
      r_mul_b_q     <= r_mul_b_d;
      r_p_q         <= r_p_d;
      r_out_re_q    <= r_out_re_d;
      r_out_im_q    <= r_out_im_d;
      r_out_valid_q <= r_out_valid_d;
      r_err_q       <= r_err_d;
    end
  end

  assign bus.in_ready  = (r_state_q == StIdle);
  assign bus.mul_start = (r_state_q == StIssue);
  assign bus.mul_a     = r_mul_a_q;
  assign bus.mul_b     = r_mul_b_q;
  assign bus.out_valid = r_out_valid_q;
  assign bus.out_re    = r_out_re_q;
  assign bus.out_im    = r_out_im_q;
  assign bus.err       = r_err_q;

endmodule

// File: tb/tb_cmul_mult_sequencer.sv
// Bench for cmul_mult_sequencer: exact signed multiplier model with 18-cycle latency,
// table-driven operand sets through a result scoreboard, plus backpressure/timeout/reset cases.
module tb_cmul_mult_sequencer;
  import cmul_mult_sequencer_pkg::*;

  localparam int L = 18;

  typedef struct { int xr; int xi; int wr; int wi; int er; int ei; } vec_t;
  typedef struct { int re; int im; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmul_mult_sequencer_if u_if ();

  cmul_mult_sequencer #(
    .TIMEOUT   (64),
    .FLUSH_CYC (20)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  // Multiplier model; inj_* lets the bench force stray result pulses.
  logic                 mdl_en = 1'b1;
  logic                 inj_valid = 1'b0;
  logic signed [PW-1:0] inj_p = '0;
  logic                 m_valid, m_busy;
  logic [4:0]           m_cnt;
  logic signed [PW-1:0] m_prod;
  logic signed [XW-1:0] m_a;
  logic signed [WW-1:0] m_b;
  int                   m_unstable = 0;

  assign u_if.mul_valid = m_valid | inj_valid;
  assign u_if.mul_p     = inj_valid ? inj_p : m_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_cnt   <= '0;
      m_prod  <= '0;
      m_a     <= '0;
      m_b     <= '0;
    end else begin
      m_valid <= 1'b0;
      if (u_if.mul_start && mdl_en) begin
        m_busy <= 1'b1;
        m_cnt  <= 5'(L - 1);
        m_a    <= u_if.mul_a;
        m_b    <= u_if.mul_b;
        m_prod <= PW'(int'(u_if.mul_a) * int'(u_if.mul_b));
      end else if (m_busy) begin
        if (m_cnt == 5'd1) begin
          m_valid <= 1'b1;
          m_busy  <= 1'b0;
          if (u_if.mul_a !== m_a || u_if.mul_b !== m_b) m_unstable <= m_unstable + 1;
        end else begin
          m_cnt <= m_cnt - 5'd1;
        end
      end
    end
  end

  int   cyc = 0;
  int   st_cyc[$];
  int   st_double = 0;
  logic st_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (u_if.mul_start) begin
      st_cyc.push_back(cyc);
      if (st_prev) st_double <= st_double + 1;
    end
    st_prev <= u_if.mul_start;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic accept(input vec_t v, input bit push, output int acc);
    int n = 0;
    while (!u_if.in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!u_if.in_ready) chk("in_ready_wait", 0, 1);
    u_if.in_valid = 1'b1;
    u_if.x_re = XW'(v.xr);
    u_if.x_im = XW'(v.xi);
    u_if.w_re = WW'(v.wr);
    u_if.w_im = WW'(v.wi);
    if (push) sb_q.push_back('{re: v.er, im: v.ei});
    @(posedge clk); #1;
    acc = cyc;
    u_if.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n0, output int n);
    n = n0;
    while (!u_if.out_valid && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!u_if.out_valid) chk("out_valid_wait", 0, 1);
  endtask

  task automatic take_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("out_re", u_if.out_re, e.re);
      chk("out_im", u_if.out_im, e.im);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_norm(input vec_t v, output int acc);
    int n;
    int base = st_cyc.size();
    accept(v, 1'b1, acc);
    wait_out(1, n);
    chk("latency", n, 78);
    chk("start_count", st_cyc.size() - base, 4);
    if (st_cyc.size() >= base + 4)
      for (int j = 0; j < 4; j++) chk("start_spacing", st_cyc[base + j] - acc, 19 * j);
    take_out();
  endtask

  vec_t tbl[7];

  initial begin
    int   acc, prev_acc, n, base;
    bit   ov_seen;

    tbl[0] = '{3, -2, 100, -50, 200, -350};
    tbl[1] = '{-128, -128, -256, -256, 0, 65536};
    tbl[2] = '{-128, 127, -256, 255, 383, -65152};
    tbl[3] = '{0, 0, 0, 0, 0, 0};
    tbl[4] = '{127, 127, 255, 255, 0, 64770};
    tbl[5] = '{1, -1, 1, -1, 0, -2};
    tbl[6] = '{-1, 5, 7, -3, 8, 38};

    u_if.in_valid  = 1'b0;
    u_if.x_re      = '0;
    u_if.x_im      = '0;
    u_if.w_re      = '0;
    u_if.w_im      = '0;
    u_if.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", u_if.in_ready, 0);
    chk("rst_out_valid", u_if.out_valid, 0);
    chk("rst_mul_start", u_if.mul_start, 0);
    chk("rst_err", u_if.err, 0);
    chk("rst_out_re", u_if.out_re, 0);
    chk("rst_mul_a", u_if.mul_a, 0);

    rst_n = 1'b1;
    n = 0;
    while (!u_if.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("flush_len", n, 20);

    for (int i = 0; i < 7; i++) begin
      run_norm(tbl[i], acc);
      if (i > 0) chk("period", acc - prev_acc, 79);
      prev_acc = acc;
    end

    // Stray result pulses in IDLE and in the start cycle must be ignored.
    inj_p = 17'sd12345;
    inj_valid = 1'b1;
    @(posedge clk); #1;
    inj_valid = 1'b0;
    base = st_cyc.size();
    accept(tbl[0], 1'b1, acc);
    chk("issue_cycle_start", u_if.mul_start, 1);
    inj_valid = 1'b1;
    @(posedge clk); #1;
    inj_valid = 1'b0;
    wait_out(2, n);
    chk("spur_latency", n, 78);
    chk("spur_starts", st_cyc.size() - base, 4);
    take_out();

    // Backpressure: result held for 10 cycles, no acceptance meanwhile.
    u_if.out_ready = 1'b0;
    accept(tbl[2], 1'b1, acc);
    wait_out(1, n);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", u_if.out_valid, 1);
      chk("hold_re", u_if.out_re, tbl[2].er);
      chk("hold_im", u_if.out_im, tbl[2].ei);
      chk("hold_in_ready", u_if.in_ready, 0);
    end
    u_if.out_ready = 1'b1;
    take_out();
    chk("post_hs_in_ready", u_if.in_ready, 1);
    chk("post_hs_out_valid", u_if.out_valid, 0);

    // Multiplier never answers: watchdog abort, flush, sticky err.
    mdl_en = 1'b0;
    base = st_cyc.size();
    ov_seen = 1'b0;
    accept(tbl[1], 1'b0, acc);
    n = 1;
    while (!u_if.err && n < 200) begin
      @(posedge clk); #1; n++;
      if (u_if.out_valid) ov_seen = 1'b1;
    end
    chk("err_cycle", n, 66);
    chk("err_set", u_if.err, 1);
    chk("to_in_ready", u_if.in_ready, 0);
    while (!u_if.in_ready && n < 300) begin
      @(posedge clk); #1; n++;
      if (u_if.out_valid) ov_seen = 1'b1;
    end
    chk("to_idle_cycle", n, 86);
    chk("to_starts", st_cyc.size() - base, 1);
    chk("to_no_out", ov_seen, 0);
    mdl_en = 1'b1;
    run_norm(tbl[6], acc);
    chk("err_sticky", u_if.err, 1);

    // Reset during the k=2 wait, stale result pulse during flush.
    base = st_cyc.size();
    accept(tbl[4], 1'b1, acc);
    n = 0;
    while (st_cyc.size() < base + 3 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("k2_reached", st_cyc.size() - base, 3);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    chk("mid_rst_out_valid", u_if.out_valid, 0);
    chk("mid_rst_in_ready", u_if.in_ready, 0);
    chk("mid_rst_err", u_if.err, 0);
    chk("mid_rst_out_re", u_if.out_re, 0);
    rst_n = 1'b1;
    ov_seen = 1'b0;
    n = 0;
    while (!u_if.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
      if (u_if.out_valid) ov_seen = 1'b1;
      inj_valid = (n == 5);
    end
    inj_valid = 1'b0;
    chk("rst_flush_len", n, 20);
    chk("rst_no_out", ov_seen, 0);
    run_norm(tbl[2], acc);

    chk("mul_ab_stable", m_unstable, 0);
    chk("start_single_cycle", st_double, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
